// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//
// Arbitrates push/pop requests from two requesters onto a single external
// stack. One requester is granted per cycle, round-robin when both ask. The
// block tracks the occupancy (255 entries max) and turns a push when full or
// a pop when empty into a granted no-op with an error pulse. Pop data is
// registered and returned one cycle after the grant.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   Req0/1, Op0/1      request, operation (0 = push, 1 = pop)
//   Data0/1            push data
//   Gnt0/1             request accepted this cycle (combinational)
//   Flush              synchronous stack clear, overrides all requests
//   RData/RValid/RId   pop data, one-cycle valid pulse, owning requester
//   Err/ErrId          rejected-op pulse and owning requester
//   Full/Empty/Count   occupancy status
//   sMode              stack command: 00 PUSH, 01 POP, 10 INIT, 11 NoOp
//   siData/siADDR      stack write data, stack address (mirrors soADDR)
//   soData/soADDR      top-of-stack word, stack pointer
// -----------------------------------------------------------------------------
module stack_arbiter (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       Req0,
    input  logic       Req1,
    input  logic       Op0,
    input  logic       Op1,
    input  logic [7:0] Data0,
    input  logic [7:0] Data1,
    output logic       Gnt0,
    output logic       Gnt1,
    input  logic       Flush,
    output logic [7:0] RData,
    output logic       RValid,
    output logic       RId,
    output logic       Err,
    output logic       ErrId,
    output logic       Full,
    output logic       Empty,
    output logic [7:0] Count,
    output logic [1:0] sMode,
    output logic [7:0] siData,
    output logic [7:0] siADDR,
    input  logic [7:0] soData,
    input  logic [7:0] soADDR
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SM_PUSH = 2'b00,
        SM_POP  = 2'b01,
        SM_INIT = 2'b10,
        SM_NOOP = 2'b11
    } smode_t;

    localparam logic [7:0] CAPACITY = 8'd255;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       ptr_q, ptr_d;       // requester that wins a tie
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       rid_q, rid_d;
    logic       err_q, err_d;
    logic       errid_q, errid_d;

    smode_t     smode_c;
    logic [7:0] sidata_c;
    logic       gnt_vld, gnt_id, gnt_op;
    logic [7:0] gnt_data;
    logic       full_c, empty_c;

    assign full_c  = (count_q == CAPACITY);
    assign empty_c = (count_q == 8'd0);

    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rid_d    = rid_q;
        err_d    = 1'b0;
        errid_d  = errid_q;
        smode_c  = SM_NOOP;
        sidata_c = 8'd0;
        gnt_vld  = 1'b0;
        gnt_id   = 1'b0;
        gnt_op   = 1'b0;
        gnt_data = 8'd0;

        case (state_q)
            S_INIT: begin
                smode_c = SM_INIT;
                count_d = 8'd0;
                state_d = S_RUN;
            end

            S_RUN: begin
                if (Flush) begin
                    smode_c = SM_INIT;
                    count_d = 8'd0;
                end else begin
                    // The pointer only matters on a tie; a lone requester wins outright.
                    if (Req0 && Req1) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ptr_q;
                    end else if (Req0 || Req1) begin
                        gnt_vld = 1'b1;
                        gnt_id  = Req1;
                    end
                    gnt_op   = gnt_id ? Op1 : Op0;
                    gnt_data = gnt_id ? Data1 : Data0;

                    if (gnt_vld) begin
                        ptr_d = ~gnt_id;
                        if (!gnt_op) begin
                            if (!full_c) begin
                                smode_c  = SM_PUSH;
                                sidata_c = gnt_data;
                                count_d  = count_q + 8'd1;
                            end else begin
                                err_d   = 1'b1;
                                errid_d = gnt_id;
                            end
                        end else begin
                            if (!empty_c) begin
                                smode_c  = SM_POP;
                                count_d  = count_q - 8'd1;
                                rdata_d  = soData;
                                rvalid_d = 1'b1;
                                rid_d    = gnt_id;
                            end else begin
                                err_d   = 1'b1;
                                errid_d = gnt_id;
                            end
                        end
                    end
                end
            end

            default: state_d = S_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_INIT;
            count_q  <= 8'd0;
            ptr_q    <= 1'b0;
            rdata_q  <= 8'd0;
            rvalid_q <= 1'b0;
            rid_q    <= 1'b0;
            err_q    <= 1'b0;
            errid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            err_q    <= err_d;
            errid_q  <= errid_d;
        end
    end

    assign Gnt0   = gnt_vld & ~gnt_id;
    assign Gnt1   = gnt_vld &  gnt_id;
    assign RData  = rdata_q;
    assign RValid = rvalid_q;
    assign RId    = rid_q;
    assign Err    = err_q;
    assign ErrId  = errid_q;
    assign Full   = full_c;
    assign Empty  = empty_c;
    assign Count  = count_q;
    assign sMode  = smode_c;
    assign siData = sidata_c;
    assign siADDR = soADDR;

endmodule

// File: tb/tb_stack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_arbiter
//
// Drives stack_arbiter against a behavioural stack memory. A reference model
// (a queue used as the stack plus a tie-break pointer) predicts the grant and
// stack command each cycle, and pushes the expected pop-data / error response
// into a scoreboard. A separate monitor pops and compares whenever the DUT
// response is due.
// -----------------------------------------------------------------------------
module tb_stack_arbiter;

    localparam logic [1:0] M_PUSH = 2'b00;
    localparam logic [1:0] M_POP  = 2'b01;
    localparam logic [1:0] M_INIT = 2'b10;
    localparam logic [1:0] M_NOOP = 2'b11;

    typedef struct {
        bit         is_err;
        bit         id;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       Req0 = 1'b0, Req1 = 1'b0, Op0 = 1'b0, Op1 = 1'b0, Flush = 1'b0;
    logic [7:0] Data0 = 8'd0, Data1 = 8'd0;
    logic       Gnt0, Gnt1, RValid, RId, Err, ErrId, Full, Empty;
    logic [7:0] RData, Count, siData, siADDR, soData, soADDR;
    logic [1:0] sMode;

    stack_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .Data0(Data0), .Data1(Data1), .Gnt0(Gnt0), .Gnt1(Gnt1),
        .Flush(Flush),
        .RData(RData), .RValid(RValid), .RId(RId),
        .Err(Err), .ErrId(ErrId), .Full(Full), .Empty(Empty), .Count(Count),
        .sMode(sMode), .siData(siData), .siADDR(siADDR),
        .soData(soData), .soADDR(soADDR)
    );

    always #5 CLK = ~CLK;

    // Behavioural stack memory commanded by sMode.
    logic [7:0] mem [256];
    logic [7:0] sp = 8'd0;
    initial for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    assign soADDR = sp;
    assign soData = mem[sp - 8'd1];
    always @(posedge CLK) begin
        case (sMode)
            M_PUSH: begin mem[sp] <= siData; sp <= sp + 8'd1; end
            M_POP:  sp <= sp - 8'd1;
            M_INIT: sp <= 8'd0;
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state.
    logic [7:0] stk[$];
    bit         prio = 1'b0;
    bit         init_pending = 1'b1;
    exp_t       sb[$];
    logic [7:0] last_rdata = 8'd0;

    // Pending requests, held until granted.
    bit         r_req[2] = '{0, 0};
    bit         r_op[2]  = '{0, 0};
    logic [7:0] r_data[2] = '{8'd0, 8'd0};

    // Response monitor.
    always @(negedge CLK) begin
        if (nRST) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("rvalid", RValid, !e.is_err);
                check("err", Err, e.is_err);
                if (e.is_err) begin
                    check("errid", ErrId, e.id);
                end else begin
                    last_rdata = e.data;
                    check("rid", RId, e.id);
                end
            end else begin
                check("rvalid_idle", RValid, 1'b0);
                check("err_idle", Err, 1'b0);
            end
            check("rdata", RData, last_rdata);
        end
    end

    // One bus cycle: drive pending requests, check the combinational response,
    // then advance the model as of the coming rising edge.
    task automatic step(input bit flush);
        bit         gv;
        bit         gid;
        logic [1:0] es;
        exp_t       e;
        @(negedge CLK);
        Req0 = r_req[0]; Op0 = r_op[0]; Data0 = r_data[0];
        Req1 = r_req[1]; Op1 = r_op[1]; Data1 = r_data[1];
        Flush = flush;
        #1;
        gv  = 1'b0;
        gid = 1'b0;
        es  = M_NOOP;
        if (init_pending || flush) begin
            es = M_INIT;
        end else if (r_req[0] || r_req[1]) begin
            gv  = 1'b1;
            gid = (r_req[0] && r_req[1]) ? prio : r_req[1];
            if (!r_op[gid]) es = (stk.size() == 255) ? M_NOOP : M_PUSH;
            else            es = (stk.size() == 0)   ? M_NOOP : M_POP;
        end

        check("gnt0", Gnt0, gv && !gid);
        check("gnt1", Gnt1, gv && gid);
        check("smode", sMode, es);
        check("count", Count, stk.size());
        check("full", Full, stk.size() == 255);
        check("empty", Empty, stk.size() == 0);
        check("siaddr", siADDR, soADDR);
        if (es == M_PUSH) check("sidata", siData, r_data[gid]);

        if (init_pending) begin
            init_pending = 1'b0;
            stk.delete();
        end else if (flush) begin
            stk.delete();
        end else if (gv) begin
            prio     = !gid;
            e.id     = gid;
            e.due    = cyc + 1;
            e.data   = 8'd0;
            e.is_err = (es == M_NOOP);
            if (es == M_PUSH) stk.push_back(r_data[gid]);
            if (es == M_POP)  e.data = stk.pop_back();
            if (es != M_PUSH) sb.push_back(e);
            r_req[gid] = 1'b0;
        end
    endtask

    task automatic clear_reqs();
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
    endtask

    task automatic set_req(input int id, input bit op, input logic [7:0] d);
        r_req[id]  = 1'b1;
        r_op[id]   = op;
        r_data[id] = d;
    endtask

    initial begin
        // Reset held with requests asserted: nothing may be granted.
        set_req(0, 1'b0, 8'h11);
        set_req(1, 1'b1, 8'h22);
        Req0 = 1'b1; Req1 = 1'b1; Data0 = 8'h11; Op1 = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        check("rst_gnt0", Gnt0, 1'b0);
        check("rst_gnt1", Gnt1, 1'b0);
        check("rst_empty", Empty, 1'b1);
        check("rst_full", Full, 1'b0);
        check("rst_smode", sMode, M_INIT);
        check("rst_count", Count, 8'd0);
        check("rst_rvalid", RValid, 1'b0);
        check("rst_err", Err, 1'b0);
        check("rst_rdata", RData, 8'd0);
        clear_reqs();

        // Release mid-cycle; the first cycle after release is the INIT cycle.
        @(posedge CLK);
        #2 nRST = 1'b1;
        step(1'b0);

        // Push 0xA5 then pop it back from requester 0.
        set_req(0, 1'b0, 8'hA5);
        step(1'b0);
        set_req(0, 1'b1, 8'h00);
        step(1'b0);
        step(1'b0);

        // Pop on empty from requester 1.
        set_req(1, 1'b1, 8'h00);
        step(1'b0);
        step(1'b0);

        // Both push continuously: alternating grants starting with the pointer.
        for (int k = 0; k < 3; k++) begin
            if (!r_req[0]) set_req(0, 1'b0, 8'(8'h10 + k));
            if (!r_req[1]) set_req(1, 1'b0, 8'(8'h20 + k));
            step(1'b0);
        end

        // Flush with Count = 3 and both requests high.
        if (!r_req[0]) set_req(0, 1'b0, 8'h30);
        if (!r_req[1]) set_req(1, 1'b0, 8'h31);
        step(1'b1);
        clear_reqs();
        step(1'b0);

        // Fill to capacity, then one push too many.
        for (int k = 0; k < 256; k++) begin
            set_req(0, 1'b0, 8'(k * 7 + 3));
            step(1'b0);
        end
        step(1'b0);

        // Randomized traffic starting from a full stack.
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!r_req[i] && ($urandom_range(2) != 0))
                    set_req(i, 1'($urandom_range(1)), 8'($urandom));
            end
            step($urandom_range(59) == 0);
        end
        clear_reqs();
        step(1'b0);

        // Reset asserted right after a pop grant abandons the RValid pulse.
        set_req(1, 1'b0, 8'h5C);
        step(1'b0);
        set_req(0, 1'b1, 8'h00);
        step(1'b0);
        @(posedge CLK);
        #1 nRST = 1'b0;
        sb.delete();
        stk.delete();
        last_rdata   = 8'd0;
        prio         = 1'b0;
        init_pending = 1'b1;
        clear_reqs();
        #1;
        check("mid_rst_rvalid", RValid, 1'b0);
        check("mid_rst_count", Count, 8'd0);
        check("mid_rst_smode", sMode, M_INIT);
        @(posedge CLK);
        #2 nRST = 1'b1;
        step(1'b0);
        set_req(0, 1'b0, 8'h77);
        set_req(1, 1'b0, 8'h88);
        step(1'b0);
        step(1'b0);
        step(1'b0);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: CLK in 1, clock, all logic on rising edge; nRST in 1, asynchronous active-low reset.
REQ-002 SHALL have requester ports Req0/Req1 in 1 (request); Op0/Op1 in 1 (0=push, 1=pop); Data0/Data1 in 8 (push data); Gnt0/Gnt1 out 1 (request accepted this cycle).
REQ-003 SHALL have Flush in 1, synchronous stack clear.
REQ-004 SHALL have RData out 8 (pop data), RValid out 1 (pop data valid pulse), RId out 1 (requester that owns RData).
REQ-005 SHALL have Err out 1 (rejected-op pulse), ErrId out 1 (requester that owns Err), Full out 1, Empty out 1, Count out 8 (entries held).
REQ-006 SHALL have stack-side ports sMode out 2 (00 PUSH, 01 POP, 10 INIT, 11 NoOp), siData out 8, siADDR out 8, soData in 8 (top-of-stack word), soADDR in 8 (stack pointer).

Function
REQ-007 SHALL implement FSM states S_INIT and S_RUN; reset enters S_INIT.
REQ-008 In S_INIT: drive sMode=INIT for exactly one cycle, assert no grant, set Count=0, go to S_RUN.
REQ-009 In S_RUN with Flush=1: drive sMode=INIT, set Count=0, grant nothing; Flush overrides all requests.
REQ-010 In S_RUN with Flush=0: grant at most one requester per cycle; grant is combinational in the cycle it is issued.
REQ-011 Arbitration SHALL be round-robin: when both Req are high, grant the requester indicated by the priority pointer.
REQ-012 After any grant, the pointer SHALL move to the other requester; after reset, requester 0 has priority.
REQ-013 A lone requester SHALL be granted immediately regardless of the pointer.
REQ-014 A requester SHALL hold Req/Op/Data stable until its Gnt; a new request may start in the cycle after Gnt.
REQ-015 Granted push with Full=0: sMode=PUSH, siData=granted Data, Count+1 at the edge.
REQ-016 Granted pop with Empty=0: sMode=POP, Count-1 at the edge, RData<=soData at the same edge; RValid=1 and RId=granted id for the next cycle only (latency 1).
REQ-017 Push with Full=1, or pop with Empty=1, SHALL still be granted (no hang), with sMode=NoOp, Count unchanged, and Err=1/ErrId=id for the next cycle only.
REQ-018 siADDR SHALL equal soADDR in every cycle.
REQ-019 With no grant and no Flush, sMode SHALL be NoOp.
REQ-020 Capacity SHALL be 255 entries: Full=(Count==255); Empty=(Count==0). Count never wraps.
REQ-021 Full and Empty SHALL be derived combinationally from registered Count.
REQ-022 RValid and Err SHALL never both be asserted for the same grant; RData holds its value when RValid=0.

Reset
REQ-023 nRST low SHALL asynchronously force: state S_INIT, Count=0, pointer=0, RData=0, RValid=0, RId=0, Err=0, ErrId=0.
REQ-024 Resulting outputs while reset is held: Gnt0=Gnt1=0, Empty=1, Full=0.
REQ-025 While nRST is low, sMode SHALL be INIT.
REQ-026 On release of reset, the first edge SHALL complete the S_INIT cycle; grants are possible from the following cycle.
REQ-027 Reset asserted mid-operation SHALL abandon any pending RValid/Err pulse.

Verification
REQ-028 Reset release, Req0 push 0xA5, then Req0 pop -> sMode INIT, PUSH, POP; RData=0xA5, RValid=1, RId=0 one cycle after the pop grant; Count 0->1->0.
REQ-029 Req0 and Req1 both push continuously -> Gnt alternates 0,1,0,1 starting with 0; Count increments each cycle.
REQ-030 255 pushes then one more push -> Full=1, the extra push is granted with sMode=NoOp, Err=1 next cycle, Count stays 255.
REQ-031 Pop on empty from Req1 -> Gnt1=1, sMode=NoOp, Err=1 with ErrId=1 next cycle, RValid=0.
REQ-032 Flush with Count=3 and both Req high -> no Gnt, sMode=INIT, Count=0, Empty=1 next cycle.
REQ-033 nRST pulsed low one cycle after a pop grant -> RValid stays 0, Count=0, and one INIT cycle follows the release.
